// File: rtl/envelope_pkg.sv
// Shared types, packet field offsets and output volume scaling for the note envelope stage.
package envelope_pkg;

  localparam int PACKET_SIZE = 24;
  typedef logic [PACKET_SIZE-1:0] packetType;

  localparam int TUNE_LSB = 8;
  localparam int TUNE_W   = 16;
  localparam int VOL_LSB  = 0;
  localparam int VOL_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } envState_t;

  // level x volume, keeping the high byte rounded to nearest without wrapping past 0xFF
  function automatic logic [7:0] scale_vol(input logic [7:0] level, input logic [7:0] vol);
    logic [15:0] prod;
    prod = 16'(level) * 16'(vol);
    if (prod[7] && !(&prod[15:8])) scale_vol = prod[15:8] + 8'd1;
    else                           scale_vol = prod[15:8];
  endfunction

endpackage

// File: rtl/envelope_step_timer.sv
// Envelope step prescaler: raises step on every TICK_DIV-th tick.
module envelope_step_timer #(
  parameter int TICK_DIV = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign step = tick && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (tick) count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/note_envelope.sv
// Per-track ADSR amplitude envelope between the SPI receiver and the tone generator.
// Define ENVELOPE_RETRIGGER_EN to restart the attack on a tune change; otherwise tune changes are legato.
module note_envelope
  import envelope_pkg::*;
#(
  parameter int TICK_DIV      = 64,
  parameter int ATTACK_INC    = 8,
  parameter int DECAY_DEC     = 4,
  parameter int SUSTAIN_LEVEL = 192,
  parameter int RELEASE_DEC   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [PACKET_SIZE-1:0] notePacketIn,
  output logic [PACKET_SIZE-1:0] notePacketOut,
  output logic                   active
);

  localparam logic [9:0] DECAY_FLOOR   = 10'(SUSTAIN_LEVEL + DECAY_DEC);
  localparam logic [9:0] RELEASE_FLOOR = 10'(RELEASE_DEC);

  envState_t         state_q, state_d;
  logic [7:0]        level_q, level_d;
  logic [TUNE_W-1:0] held_tune_q, held_tune_d;
  logic [VOL_W-1:0]  held_vol_q, held_vol_d;
  packetType         pkt_out_q, pkt_out_d;

  logic              step;
  logic              event_hit;
  logic [TUNE_W-1:0] tune_in;
  logic [VOL_W-1:0]  vol_in;
  logic [8:0]        attack_sum;

  assign tune_in    = notePacketIn[TUNE_LSB +: TUNE_W];
  assign vol_in     = notePacketIn[VOL_LSB +: VOL_W];
  assign attack_sum = {1'b0, level_q} + 9'(ATTACK_INC);

  envelope_step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .step  (step)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    held_tune_d = held_tune_q;
    held_vol_d  = held_vol_q;
    pkt_out_d   = pkt_out_q;
    event_hit   = 1'b0;

    if (tick) begin
      // output reflects the envelope as it stood before this tick's update
      pkt_out_d = {held_tune_q, scale_vol(level_q, held_vol_q)};
      if (state_q != IDLE && state_q != RELEASE) held_vol_d = vol_in;

      case (state_q)
        IDLE, RELEASE: begin
          if (tune_in != '0) begin
            held_tune_d = tune_in;
            state_d     = ATTACK;
            event_hit   = 1'b1;
          end
        end
        default: begin
          if (tune_in == '0) begin
            state_d   = RELEASE;
            event_hit = 1'b1;
          end else if (tune_in != held_tune_q) begin
            held_tune_d = tune_in;
`ifdef ENVELOPE_RETRIGGER_EN
            state_d     = ATTACK;
            event_hit   = 1'b1;
`endif
          end
        end
      endcase

      if (step && !event_hit) begin
        case (state_q)
          ATTACK: begin
            if (attack_sum >= 9'd255) begin
              level_d = 8'd255;
              state_d = DECAY;
            end else begin
              level_d = attack_sum[7:0];
            end
          end
          DECAY: begin
            if ({2'b00, level_q} <= DECAY_FLOOR) begin
              level_d = 8'(SUSTAIN_LEVEL);
              state_d = SUSTAIN;
            end else begin
              level_d = level_q - 8'(DECAY_DEC);
            end
          end
          RELEASE: begin
            if ({2'b00, level_q} <= RELEASE_FLOOR) begin
              level_d     = 8'd0;
              state_d     = IDLE;
              held_tune_d = '0;
            end else begin
              level_d = level_q - 8'(RELEASE_DEC);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      level_q     <= '0;
      held_tune_q <= '0;
      held_vol_q  <= '0;
      pkt_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      held_tune_q <= held_tune_d;
      held_vol_q  <= held_vol_d;
      pkt_out_q   <= pkt_out_d;
    end
  end

  assign notePacketOut = pkt_out_q;
  assign active        = (state_q != IDLE);

endmodule

// File: tb/tb_note_envelope.sv
// Directed bench for note_envelope with fast envelope parameters; one tick every 256 clk.
module tb_note_envelope;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [23:0] pkt_in = '0;
  logic [23:0] pkt_out;
  logic        active;

  int n_checks = 0;
  int n_pass   = 0;

  note_envelope #(
    .TICK_DIV      (2),
    .ATTACK_INC    (64),
    .DECAY_DEC     (32),
    .SUSTAIN_LEVEL (192),
    .RELEASE_DEC   (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .notePacketIn  (pkt_in),
    .notePacketOut (pkt_out),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (254) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if (pkt_out !== 24'h0) $display("FAIL reset_out: got %h want %h", pkt_out, 24'h0);
    else n_pass++;
    n_checks++;
    if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active);
    else n_pass++;
    pkt_in = 24'h0;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      n_checks++;
      if (pkt_out !== 24'h0 || active !== 1'b0)
        $display("FAIL reset_hold tick %0d: got %h/%b want 000000/0", i, pkt_out, active);
      else n_pass++;
    end
  endtask

  task automatic test_attack_decay();
    logic [23:0] exp_out [16] = '{24'h000000, 24'h123400, 24'h123420, 24'h123420,
                                  24'h123440, 24'h123440, 24'h123460, 24'h123460,
                                  24'h123480, 24'h123480, 24'h123470, 24'h123470,
                                  24'h123460, 24'h123460, 24'h123460, 24'h123460};
    pkt_in = 24'h123480;
    for (int i = 0; i < 16; i++) begin
      do_tick();
      n_checks++;
      if (pkt_out !== exp_out[i] || active !== 1'b1)
        $display("FAIL attack_decay tick %0d: got %h/%b want %h/1", i, pkt_out, active, exp_out[i]);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    logic [23:0] exp_out [8] = '{24'h123460, 24'h123460, 24'h123440, 24'h123440,
                                 24'h123420, 24'h123420, 24'h000000, 24'h000000};
    logic        exp_act [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    pkt_in = 24'h000080;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      n_checks++;
      if (pkt_out !== exp_out[i] || active !== exp_act[i])
        $display("FAIL release tick %0d: got %h/%b want %h/%b", i, pkt_out, active, exp_out[i], exp_act[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reattack();
    logic [23:0] exp_out [10] = '{24'h123440, 24'h123440, 24'h123460, 24'h123460, 24'h123480,
                                  24'h123480, 24'h123470, 24'h123470, 24'h123460, 24'h123460};
    pkt_in = 24'h123480;
    repeat (14) do_tick();
    pkt_in = 24'h000080;
    repeat (2) do_tick();
    n_checks++;
    if (pkt_out !== 24'h123460 || active !== 1'b1)
      $display("FAIL reattack_setup: got %h/%b want 123460/1", pkt_out, active);
    else n_pass++;
    pkt_in = 24'h123480;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      n_checks++;
      if (pkt_out !== exp_out[i])
        $display("FAIL reattack tick %0d: got %h want %h", i, pkt_out, exp_out[i]);
      else n_pass++;
    end
  endtask

  task automatic test_retrigger();
`ifdef ENVELOPE_RETRIGGER_EN
    logic [23:0] exp_out [8] = '{24'h123460, 24'h200060, 24'h200080, 24'h200080,
                                 24'h200070, 24'h200070, 24'h200060, 24'h200060};
`else
    logic [23:0] exp_out [8] = '{24'h123460, 24'h200060, 24'h200060, 24'h200060,
                                 24'h200060, 24'h200060, 24'h200060, 24'h200060};
`endif
    pkt_in = 24'h200080;
    for (int i = 0; i < 8; i++) begin
      do_tick();
      n_checks++;
      if (pkt_out !== exp_out[i] || active !== 1'b1)
        $display("FAIL retrigger tick %0d: got %h/%b want %h/1", i, pkt_out, active, exp_out[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] exp_out [5] = '{24'h000000, 24'h123400, 24'h123420, 24'h123420, 24'h123440};
    do_reset(3);
    pkt_in = 24'h123480;
    repeat (4) do_tick();
    n_checks++;
    if (pkt_out !== 24'h123420 || active !== 1'b1)
      $display("FAIL mid_reset_setup: got %h/%b want 123420/1", pkt_out, active);
    else n_pass++;
    do_reset(1);
    n_checks++;
    if (pkt_out !== 24'h0 || active !== 1'b0)
      $display("FAIL mid_reset_clear: got %h/%b want 000000/0", pkt_out, active);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      n_checks++;
      if (pkt_out !== exp_out[i])
        $display("FAIL mid_reset_restart tick %0d: got %h want %h", i, pkt_out, exp_out[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_release();
    test_reattack();
    test_retrigger();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_envelope.md
# note_envelope

Per-track amplitude envelope stage between the SPI receiver and the tone generator. It consumes the raw 24-bit note packet {tuneWord[23:8], volume[7:0]} and emits a packet of the same format. The output volume follows an attack/decay/sustain/release (ADSR) envelope, and the tuneWord is held through release so notes fade out instead of clicking off. One instance per track sits in `top`, with its output driving that track's `toneGenerator.notePacket`.

## Interface
- `TICK_DIV`, 64: `tick` strobes per envelope step (156.25 kHz / 64 ≈ 2.44 kHz step rate); must be ≥1.
- `ATTACK_INC`, 8: level increment per step in ATTACK.
- `DECAY_DEC`, 4: level decrement per step in DECAY.
- `SUSTAIN_LEVEL`, 192: level held in SUSTAIN.
- `RELEASE_DEC`, 2: level decrement per step in RELEASE.
- `clk` in 1: system clock, 40 MHz.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `tick` in 1: one-cycle strobe, tied to `wgEn`.
- `notePacketIn` in 24: packet from `spi`.
- `notePacketOut` out 24: {heldTune, scaledVol} to `toneGenerator`.
- `active` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Registers:
  - `level`: 8-bit unsigned.
  - `heldTune`: 16-bit.
  - `heldVol`: 8-bit.
  - prescaler: counts 0..TICK_DIV-1.
- Reset values: state IDLE, all registers 0, `notePacketOut` = 0, `active` = 0.
- Events are evaluated on every `tick`. `step` = `tick` & prescaler == TICK_DIV-1. The prescaler wraps to 0 on `step`.
- Note-on: tuneIn ≠ 0 while in IDLE or RELEASE.
  - Action: heldTune ← tuneIn, state ← ATTACK.
  - `level` is not cleared, so a restart from RELEASE continues from the current level.
- Note-off: tuneIn == 0 while in ATTACK, DECAY or SUSTAIN.
  - Action: state ← RELEASE. `heldTune` is kept.
- `heldVol` ← volIn on every `tick` except in RELEASE and IDLE, where it freezes.
- Level stepping (on `step`, when no event occurred in the same tick):
  - ATTACK: if level + ATTACK_INC (9-bit) ≥ 255, then level ← 255 and state ← DECAY; otherwise add.
  - DECAY: if level ≤ SUSTAIN_LEVEL + DECAY_DEC, then level ← SUSTAIN_LEVEL and state ← SUSTAIN; otherwise subtract.
  - RELEASE: if level ≤ RELEASE_DEC, then level ← 0, state ← IDLE, heldTune ← 0; otherwise subtract.
  - SUSTAIN, IDLE: no change.
- Output scaling: prod = level × heldVol (16-bit). scaledVol = prod[15:8] + 1 if prod[7] & ~&prod[15:8], otherwise prod[15:8] (rounding with saturation).
- A tune change in ATTACK, DECAY or SUSTAIN follows the retrigger rule (see Configuration).

## Timing
- All state and output registers update only on `tick` cycles, or on `reset`.
- `notePacketOut` is registered from the values present before the update. Latency from input change to output is one tick (256 clk).
  - `toneGenerator` samples on the same `wgEn` edge, so it sees the new value one tick later.
- Simultaneous event and `step`: the event wins. `level` is unchanged in that tick and the prescaler still advances.
- `reset` mid-operation: all registers return to reset values on the next clk edge, regardless of `tick`.
- Note-on arriving in the same tick that RELEASE would reach 0: note-on wins. State goes to ATTACK with level unchanged.

## Configuration
- `ENVELOPE_RETRIGGER_EN`
  - Defined: a different nonzero tuneIn in ATTACK, DECAY or SUSTAIN sets heldTune ← tuneIn and state ← ATTACK, with `level` kept.
  - Undefined (legato): heldTune ← tuneIn and the state is unchanged.

## Structure
- `envelope_pkg` holds:
  - `PACKET_SIZE` = 24 and `packetType`.
  - the `envState_t` enum.
  - the tune/volume field offset constants.
- Sub-module `envelope_step_timer`: the prescaler, producing `step` from `tick` and `TICK_DIV`.
- Level/FSM logic and output scaling live in `note_envelope`.

## Test plan
Bench parameters: TICK_DIV=2, ATTACK_INC=64, DECAY_DEC=32, SUSTAIN_LEVEL=192, RELEASE_DEC=64; `tick` every 256 clk.

1. Reset: assert `reset` for 3 clk → `notePacketOut` = 0, `active` = 0. Both hold for 10 ticks with input 0.
2. Attack/decay: notePacketIn = 0x123480.
   - Output tune becomes 0x1234.
   - Across steps, the output volume goes 0x00 → 0x20 → 0x40 → 0x60 → 0x80 (level 255) → 0x70 (223) → 0x60 (SUSTAIN at 192), then stays at 0x60.
3. Release: input 0x000080 from SUSTAIN.
   - Tune stays 0x1234; volume goes 0x40 → 0x20 → 0x00.
   - Then tune becomes 0x0000 and `active` = 0.
4. Re-attack: note-on 0x123480 issued in RELEASE at level 128 → volume goes 0x40 → 0x60 → 0x80. It does not restart from 0.
5. Retrigger: in SUSTAIN, tune changes to 0x2000.
   - With `ENVELOPE_RETRIGGER_EN`: state ATTACK; volume 0x60 → 0x80 → decays back to 0x60.
   - Without it: tune 0x2000 and volume steady at 0x60.
6. Mid-ramp reset: assert `reset` during ATTACK (level 128) → next clk output = 0 and IDLE. The next note-on attacks from level 0.
